// File: rtl/syscall_sequencer.sv
// Multi-cycle executor for JRRA syscalls: stalls the CPU, reads memory or registers,
// streams words to the console, writes ACC for get_int, then pulses done.
module syscall_sequencer #(
  parameter int             DW        = 8,
  parameter int             AW        = 8,
  parameter int             NUM_REGS  = 4,
  parameter logic [AW-1:0]  STACK_TOP = 8'hFF,
  parameter int             MAX_STR   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          syscall_req,
  input  logic [2:0]    code,
  input  logic [DW-1:0] acc,
  input  logic [AW-1:0] sp,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    reg_sel,
  input  logic [DW-1:0] reg_rdata,
  output logic          acc_we,
  output logic [DW-1:0] acc_wdata,
  output logic          con_valid,
  output logic [DW-1:0] con_data,
  output logic [1:0]    con_type,
  input  logic          con_ready
);

  localparam logic [2:0] C_STR   = 3'b001;
  localparam logic [2:0] C_INT   = 3'b010;
  localparam logic [2:0] C_ACC   = 3'b100;
  localparam logic [2:0] C_REGS  = 3'b101;
  localparam logic [2:0] C_STACK = 3'b110;

  localparam int            CW       = $clog2(MAX_STR + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_STR);
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EMIT, S_ACCWR, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  // State and syscall context registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
      ptr_q   <= '0;
      sp_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    sp_d      = sp_q;
    count_d   = count_q;
    data_d    = data_q;
    err_d     = err_q;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    reg_sel   = 3'd0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    con_valid = 1'b0;
    con_data  = '0;
    con_type  = 2'd0;

    case (state_q)
      S_IDLE: begin
        stall = syscall_req;
        if (syscall_req) begin
          code_d  = code;
          sp_d    = sp;
          count_d = '0;
          err_d   = 1'b0;
          case (code)
            C_STR, C_INT: begin
              ptr_d   = AW'(acc);
              state_d = S_RD;
            end
            C_ACC: begin
              data_d  = acc;
              state_d = S_EMIT;
            end
            C_REGS: begin
              ptr_d   = '0;
              state_d = S_EMIT;
            end
            C_STACK: begin
              ptr_d   = STACK_TOP;
              state_d = (sp == STACK_TOP) ? S_DONE : S_RD;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = ptr_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        stall  = 1'b1;
        data_d = mem_rdata;
        if (code_q == C_INT) begin
          state_d = S_ACCWR;
        end else if ((code_q == C_STR) && (mem_rdata == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_ACCWR: begin
        stall     = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = data_q;
        state_d   = S_DONE;
      end
      S_EMIT: begin
        stall     = 1'b1;
        con_valid = 1'b1;
        case (code_q)
          C_REGS: begin
            reg_sel  = ptr_q[2:0];
            con_data = reg_rdata;
            con_type = 2'd2;
          end
          C_ACC: begin
            con_data = data_q;
            con_type = 2'd1;
          end
          C_STACK: begin
            con_data = data_q;
            con_type = 2'd3;
          end
          default: begin
            con_data = data_q;
            con_type = 2'd0;
          end
        endcase
        // Pointer/count only move on the handshake so the word stays stable while stalled
        if (con_ready) begin
          case (code_q)
            C_STR: begin
              ptr_d   = ptr_q + AW'(1);
              count_d = count_q + CW'(1);
              state_d = ((count_q + CW'(1)) == MAX_CNT) ? S_DONE : S_RD;
            end
            C_REGS: begin
              if (ptr_q == LAST_REG) begin
                state_d = S_DONE;
              end else begin
                ptr_d   = ptr_q + AW'(1);
                state_d = S_EMIT;
              end
            end
            C_STACK: begin
              ptr_d   = ptr_q - AW'(1);
              state_d = ((ptr_q - AW'(1)) == sp_q) ? S_DONE : S_RD;
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed testbench for syscall_sequencer: memory/register models, console monitor,
// and hand-computed expectations for each syscall.
module tb_syscall_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, syscall_req;
  logic [2:0] code;
  logic [7:0] acc, sp;
  logic       stall, done, err, mem_rd, acc_we, con_valid;
  logic [7:0] mem_addr, mem_rdata, reg_rdata, acc_wdata, con_data;
  logic [2:0] reg_sel;
  logic [1:0] con_type;
  logic       con_ready = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] regs [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  syscall_sequencer dut (
    .clk(clk), .rst_n(rst_n), .syscall_req(syscall_req), .code(code), .acc(acc), .sp(sp),
    .stall(stall), .done(done), .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .reg_sel(reg_sel), .reg_rdata(reg_rdata), .acc_we(acc_we),
    .acc_wdata(acc_wdata), .con_valid(con_valid), .con_data(con_data), .con_type(con_type),
    .con_ready(con_ready)
  );

  // Memory returns data one cycle after the read strobe; register file reads combinationally
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  assign reg_rdata = regs[reg_sel];

  // Console ready: always high, or held low 3 cycles per word in slow mode
  logic slow = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (!slow) begin
      con_ready <= 1'b1;
      wcnt      <= 0;
    end else if (con_valid) begin
      if (wcnt == 3) begin
        con_ready <= 1'b1;
        wcnt      <= 0;
      end else begin
        con_ready <= 1'b0;
        wcnt      <= wcnt + 1;
      end
    end else begin
      con_ready <= 1'b0;
      wcnt      <= 0;
    end
  end

  // Monitor: console words, memory read addresses, ACC writes, console stability
  logic [7:0] con_dq [$];
  logic [1:0] con_tq [$];
  logic [7:0] rd_aq  [$];
  int         acc_we_n = 0;
  logic [7:0] acc_wd_last = 8'h00;
  int         unstable = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic [1:0] hold_t = 2'd0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (con_valid && con_ready) begin
        con_dq.push_back(con_data);
        con_tq.push_back(con_type);
      end
      if (mem_rd) rd_aq.push_back(mem_addr);
      if (acc_we) begin
        acc_we_n    <= acc_we_n + 1;
        acc_wd_last <= acc_wdata;
      end
      if (hold_pend && (!con_valid || con_data != hold_d || con_type != hold_t))
        unstable <= unstable + 1;
      hold_pend <= con_valid && !con_ready;
      hold_d    <= con_data;
      hold_t    <= con_type;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one syscall, hold req until done, count cycles and stall drops
  task automatic run_sys(input logic [2:0] c, input logic [7:0] a, input logic [7:0] s,
                         output int lat, output logic e, output int stall_bad);
    @(negedge clk);
    syscall_req = 1'b1;
    code = c;
    acc  = a;
    sp   = s;
    lat = 0;
    stall_bad = 0;
    #1;
    while (!done && lat < 2000) begin
      if (!stall) stall_bad++;
      @(negedge clk);
      acc  = 8'hA5;
      sp   = 8'h00;
      code = 3'b100;
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    e = err;
    syscall_req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  int lat, sb, cb, rb, ab, ub;
  logic e;

  initial begin
    rst_n = 1'b0; syscall_req = 1'b0; code = 3'd0; acc = 8'h00; sp = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    regs[0] = 8'd5; regs[1] = 8'd6; regs[2] = 8'd7; regs[3] = 8'd8;
    regs[4] = 8'hEE; regs[5] = 8'hEE; regs[6] = 8'hEE; regs[7] = 8'hEE;
    repeat (3) @(negedge clk);
    check("reset_outs", {26'd0, stall, done, err, con_valid, mem_rd, acc_we}, 32'd0);
    rst_n = 1'b1;

    // print_string "Hi\0"
    mem[8'h20] = 8'h48; mem[8'h21] = 8'h69; mem[8'h22] = 8'h00;
    cb = con_dq.size(); rb = rd_aq.size(); ab = acc_we_n;
    run_sys(3'b001, 8'h20, 8'h00, lat, e, sb);
    check("str_n", con_dq.size() - cb, 32'd2);
    check("str_c0", {24'd0, con_dq[cb]}, 32'h48);
    check("str_c1", {24'd0, con_dq[cb+1]}, 32'h69);
    check("str_t0", {30'd0, con_tq[cb]}, 32'd0);
    check("str_reads", rd_aq.size() - rb, 32'd3);
    check("str_addr_last", {24'd0, rd_aq[rb+2]}, 32'h22);
    check("str_no_acc", acc_we_n - ab, 32'd0);
    check("str_err", {31'd0, e}, 32'd0);
    check("str_stall", sb, 32'd0);

    // get_int
    mem[8'h40] = 8'h2A;
    cb = con_dq.size(); rb = rd_aq.size(); ab = acc_we_n;
    run_sys(3'b010, 8'h40, 8'h00, lat, e, sb);
    check("int_we", acc_we_n - ab, 32'd1);
    check("int_wdata", {24'd0, acc_wd_last}, 32'h2A);
    check("int_reads", rd_aq.size() - rb, 32'd1);
    check("int_addr", {24'd0, rd_aq[rb]}, 32'h40);
    check("int_no_con", con_dq.size() - cb, 32'd0);

    // print_acc (acc changed after issue must be ignored)
    cb = con_dq.size(); rb = rd_aq.size();
    run_sys(3'b100, 8'h77, 8'h00, lat, e, sb);
    check("acc_lat", lat, 32'd2);
    check("acc_n", con_dq.size() - cb, 32'd1);
    check("acc_data", {24'd0, con_dq[cb]}, 32'h77);
    check("acc_type", {30'd0, con_tq[cb]}, 32'd1);
    check("acc_reads", rd_aq.size() - rb, 32'd0);

    // print_regs with slow console
    slow = 1'b1;
    cb = con_dq.size(); ub = unstable;
    run_sys(3'b101, 8'h00, 8'h00, lat, e, sb);
    slow = 1'b0;
    check("regs_n", con_dq.size() - cb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("regs_data", {24'd0, con_dq[cb+i]}, 32'd5 + i);
      check("regs_type", {30'd0, con_tq[cb+i]}, 32'd2);
    end
    check("regs_stable", unstable - ub, 32'd0);
    check("regs_stall", sb, 32'd0);

    // print_stack, three entries
    mem[8'hFF] = 8'd1; mem[8'hFE] = 8'd2; mem[8'hFD] = 8'd3;
    cb = con_dq.size(); rb = rd_aq.size();
    run_sys(3'b110, 8'h00, 8'hFC, lat, e, sb);
    check("stk_n", con_dq.size() - cb, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("stk_data", {24'd0, con_dq[cb+i]}, 32'd1 + i);
      check("stk_type", {30'd0, con_tq[cb+i]}, 32'd3);
      check("stk_addr", {24'd0, rd_aq[rb+i]}, 32'hFF - i);
    end

    // print_stack, empty
    cb = con_dq.size(); rb = rd_aq.size();
    run_sys(3'b110, 8'h00, 8'hFF, lat, e, sb);
    check("stk_empty_con", con_dq.size() - cb, 32'd0);
    check("stk_empty_rd", rd_aq.size() - rb, 32'd0);
    check("stk_empty_err", {31'd0, e}, 32'd0);

    // illegal code
    cb = con_dq.size(); rb = rd_aq.size(); ab = acc_we_n;
    run_sys(3'b011, 8'h20, 8'h10, lat, e, sb);
    check("ill_err", {31'd0, e}, 32'd1);
    check("ill_lat", lat, 32'd1);
    check("ill_quiet", (con_dq.size() - cb) + (rd_aq.size() - rb) + (acc_we_n - ab), 32'd0);

    // string without NUL wrapping past 0xFF stops after 32 bytes
    for (int i = 0; i < 16; i++) begin
      mem[8'hF0 + i] = 8'h80 + 8'(i);
      mem[i] = 8'h40 + 8'(i);
    end
    cb = con_dq.size(); rb = rd_aq.size();
    run_sys(3'b001, 8'hF0, 8'h00, lat, e, sb);
    check("long_n", con_dq.size() - cb, 32'd32);
    check("long_first", {24'd0, con_dq[cb]}, 32'h80);
    check("long_last", {24'd0, con_dq[cb+31]}, 32'h4F);
    check("long_reads", rd_aq.size() - rb, 32'd32);
    check("long_wrap_addr", {24'd0, rd_aq[rb+16]}, 32'h00);

    // reset in the middle of a print_string
    @(negedge clk);
    syscall_req = 1'b1; code = 3'b001; acc = 8'h20;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; syscall_req = 1'b0;
    @(negedge clk);
    check("rst_mid", {28'd0, stall, con_valid, done, mem_rd}, 32'd0);
    rst_n = 1'b1;
    cb = con_dq.size();
    run_sys(3'b100, 8'h33, 8'h00, lat, e, sb);
    check("post_rst_data", {24'd0, con_dq[cb]}, 32'h33);
    check("post_rst_lat", lat, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
